bin_to_digits: RTL and testbench
================================

Name: bin_to_digits

Overview:
- Sequential binary-to-digit converter that sits directly upstream of the 4-digit seven-segment display driver.
- Accepts an ALU result word and produces four 4-bit digit codes d0..d3, d0 being the least significant.
- Decimal mode uses an iterative shift-and-add-3 (double-dabble) engine; hex mode uses a direct nibble split.
- Digit outputs are registered and held stable between conversions, so the display never shows partial results.

Parameters:
WIDTH, 8, input word width; legal range 4..13 so that the maximum magnitude fits in 4 BCD digits.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  conversion request; sampled only in IDLE
value  in  WIDTH  word to convert; captured on the accepted start edge
signed_mode  in  1  1 = interpret value as two's complement; captured with value
hex_mode  in  1  1 = hex nibble output, 0 = decimal BCD; captured with value
busy  out  1  high while a conversion is in progress
done  out  1  single-cycle pulse when new digits become valid
neg  out  1  sign of the last result (decimal signed mode only)
d0, d1, d2, d3  out  4 each  digit codes that feed the display driver

Behaviour:
- Reset: state = IDLE; busy, done and neg = 0; d0..d3 = 0; internal shift/BCD registers cleared. Reset mid-conversion aborts the conversion immediately; no done pulse follows.
- States:
  - IDLE: start=1 captures value, signed_mode and hex_mode, then goes to SHIFT.
  - SHIFT: lasts exactly WIDTH cycles, counter 0..WIDTH-1, then goes to FINISH.
  - FINISH: lasts one cycle, then returns to IDLE.
- busy = (state != IDLE), so busy is high in SHIFT and FINISH.
- start while busy is ignored and is not queued.
- Timing, with the start-accept edge called T:
  - SHIFT iterations occur on edges T+1..T+WIDTH.
  - The edge T+WIDTH+1 loads d0..d3 and neg, and raises done for exactly one cycle while the state returns to IDLE.
  - Latency is WIDTH+1 cycles after the accept edge, identical in every mode.
- Back-to-back: start asserted in the done cycle (state IDLE) is accepted. d0..d3 keep their previous values until the next done.
- Magnitude:
  - If signed_mode=1 and value[WIDTH-1]=1, magnitude = two's-complement negation, computed in WIDTH+1 bits so the most-negative input is handled (8-bit 0x80 gives 128).
  - Otherwise magnitude = value, zero-extended.
- Decimal engine: a 16-bit BCD register plus the magnitude shift register. Each SHIFT cycle:
  - every BCD nibble >= 5 gets +3;
  - then the BCD and magnitude registers shift left together by 1, with the magnitude MSB entering BCD bit 0.
- Hex mode:
  - The engine still runs for timing uniformity, but its result is discarded.
  - d0..d3 = value zero-extended to 16 bits, split into nibbles (d0 = bits 3:0).
  - neg = 0. signed_mode is ignored.
- Decimal output:
  - d0..d3 = BCD nibbles (d0 = ones).
  - neg = 1 only when signed_mode=1 and the input was negative; value 0 always gives neg=0.
  - All digits stay in 0..9, and the range limit on WIDTH guarantees no overflow.
- Leading zeros are not blanked; blanking is the display side's concern.

Decomposition:
- Package disp_pkg:
  - state enum (IDLE, SHIFT, FINISH);
  - constants NUM_DIGITS=4, BCD_ADJ_THRESH=5, BCD_ADJ_ADD=3;
  - typedef digit_t = logic [3:0].
- One combinational sub-module, bcd_adjust (a 4-bit nibble maps to nibble+3 if >=5, else unchanged), instantiated NUM_DIGITS times.

Test Plan:
- Unsigned decimal: value=0xFF, signed_mode=0, hex_mode=0, start pulse at T -> busy high T+1..T+9, done at T+9 only, {d3,d2,d1,d0}={0,2,5,5}, neg=0.
- Signed extreme: value=0x80, signed_mode=1 -> {0,1,2,8}, neg=1. value=0x7F -> {0,1,2,7}, neg=0. value=0x00 -> {0,0,0,0}, neg=0.
- Hex mode: value=0xA7, hex_mode=1, signed_mode=1 -> {0,0,A,7}, neg=0, done at T+9 (same latency as decimal).
- Start while busy: start 0x12, then start 0x34 at T+3 -> a single done at T+9 with {0,0,1,8}; the second request produces no effect.
- Reset mid-operation: start 0xFF, assert rst at T+4 -> all outputs 0 immediately, no done pulse. After release, start 0x05 -> {0,0,0,5}.
- Back-to-back: start 0x09, then start 0x63 in its done cycle -> first done shows {0,0,0,9}, held until the second done WIDTH+1 cycles later shows {0,0,9,9}.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the binary-to-digit converter that feeds
// the 4-digit seven-segment display driver.
//   state_t  : converter FSM states (also exported as a debug signal)
//   digit_t  : one 4-bit digit code as seen by the display driver
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;

    localparam int NUM_DIGITS     = 4;
    // Double-dabble correction: a BCD nibble that would reach 10 or more
    // after the next doubling is pre-biased by 3 so the carry lands in the
    // next decimal digit.
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bin_to_digits_if.sv
// Bus between the converter and its requester / the display driver.
//   start, value, signed_mode, hex_mode : request side (master drives)
//   busy, done, neg, d0..d3             : status and digit outputs
//   state                               : FSM state, for observation only
//
// Handshake: there is no ready signal. start is a one-cycle request that the
// converter samples only while busy is low (state IDLE); value, signed_mode
// and hex_mode must be valid in that same cycle. A start seen while busy is
// dropped, not queued. done pulses for one cycle when d0..d3/neg update, and
// start may be raised again in that very cycle.
interface bin_to_digits_if
    import disp_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             signed_mode;
    logic             hex_mode;
    logic             busy;
    logic             done;
    logic             neg;
    digit_t           d0;
    digit_t           d1;
    digit_t           d2;
    digit_t           d3;
    state_t           state;

    modport master (
        output start, value, signed_mode, hex_mode,
        input  busy, done, neg, d0, d1, d2, d3, state
    );

    modport slave (
        input  start, value, signed_mode, hex_mode,
        output busy, done, neg, d0, d1, d2, d3, state
    );

endinterface

// File: rtl/bin_to_digits_bcd_adjust.sv
// One double-dabble correction cell: a nibble of 5 or more gets +3,
// otherwise it passes through unchanged. Purely combinational.
//   nibble   : BCD digit before the shift
//   adjusted : corrected digit
module bcd_adjust
    import disp_pkg::*;
(
    input  digit_t nibble,
    output digit_t adjusted
);

    assign adjusted = (nibble >= digit_t'(BCD_ADJ_THRESH))
                    ? nibble + digit_t'(BCD_ADJ_ADD)
                    : nibble;

endmodule

// File: rtl/bin_to_digits.sv
// Sequential binary-to-digit converter. A captured word is turned into four
// digit codes, either BCD (shift-and-add-3 over WIDTH cycles) or hex nibbles.
// Hex mode still runs the engine so latency is WIDTH+1 cycles in every mode.
// Digit outputs are registered and only change on the done cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/status/digit bus (slave side), see bin_to_digits_if
// WIDTH must stay within 4..13 so the largest magnitude fits in 4 BCD digits.
module bin_to_digits
    import disp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    bin_to_digits_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] mag_q;
    logic [15:0]      bcd_q;
    logic [15:0]      bcd_adj;
    logic [15:0]      hex_word;
    logic             hex_q;
    logic             sign_q;
    logic             accept;
    logic             in_neg;
    logic [WIDTH:0]   mag_in;

    assign accept   = (state == IDLE) && bus.start;
    assign bus.busy  = (state != IDLE);
    assign bus.state = state;
    assign hex_word  = 16'(word_q);

    // Negate in WIDTH+1 bits so the most-negative input yields 2**(WIDTH-1);
    // that magnitude still fits in the low WIDTH bits as an unsigned value.
    always_comb begin
        in_neg = bus.signed_mode & bus.value[WIDTH-1];
        mag_in = in_neg ? -{1'b0, bus.value} : {1'b0, bus.value};
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
        bcd_adjust u_adj (
            .nibble   (bcd_q[4*i +: 4]),
            .adjusted (bcd_adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)   state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            word_q  <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            hex_q   <= 1'b0;
            sign_q  <= 1'b0;
            bus.done <= 1'b0;
            bus.neg  <= 1'b0;
            bus.d0   <= '0;
            bus.d1   <= '0;
            bus.d2   <= '0;
            bus.d3   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q <= bus.value;
                        hex_q  <= bus.hex_mode;
                        sign_q <= in_neg;
                        mag_q  <= mag_in[WIDTH-1:0];
                        bcd_q  <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    // Adjust first, then shift BCD and magnitude as one register.
                    bcd_q <= {bcd_adj[14:0], mag_q[WIDTH-1]};
                    mag_q <= mag_q << 1;
                    cnt   <= cnt + 1'b1;
                end
                FINISH: begin
                    bus.done <= 1'b1;
                    if (hex_q) begin
                        bus.d0  <= hex_word[3:0];
                        bus.d1  <= hex_word[7:4];
                        bus.d2  <= hex_word[11:8];
                        bus.d3  <= hex_word[15:12];
                        bus.neg <= 1'b0;
                    end else begin
                        bus.d0  <= bcd_q[3:0];
                        bus.d1  <= bcd_q[7:4];
                        bus.d2  <= bcd_q[11:8];
                        bus.d3  <= bcd_q[15:12];
                        bus.neg <= sign_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_digits.sv
// Self-checking bench for bin_to_digits (WIDTH=8): directed cases plus random
// conversions compared against an arithmetic reference model.
module tb_bin_to_digits;
    import disp_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;

    int n_checks;
    int n_err;

    logic [16:0] exp_q[$];   // {neg, d3, d2, d1, d0}
    logic [16:0] last_out;   // what the outputs must hold between conversions

    bin_to_digits_if #(.WIDTH(W)) bus ();

    bin_to_digits #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] observed();
        return {bus.neg, bus.d3, bus.d2, bus.d1, bus.d0};
    endfunction

    // Reference: plain arithmetic on the magnitude, digits by div/mod.
    function automatic logic [16:0] model(input logic [W-1:0] v, input bit sm, input bit hm);
        int mag;
        bit n;
        if (hm) return {1'b0, 16'(v)};
        n   = sm && v[W-1];
        mag = n ? (1 << W) - int'(v) : int'(v);
        return {n, 4'((mag / 1000) % 10), 4'((mag / 100) % 10),
                   4'((mag / 10) % 10), 4'(mag % 10)};
    endfunction

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Driver + per-cycle checks for one full conversion. Called just after a
    // clock edge; returns just after the done edge (the done cycle).
    task automatic run_conv(input logic [W-1:0] v, input bit sm, input bit hm);
        logic [16:0] exp;
        exp_q.push_back(model(v, sm, hm));
        bus.value       = v;
        bus.signed_mode = sm;
        bus.hex_mode    = hm;
        bus.start       = 1'b1;
        wait_cycle();
        bus.start = 1'b0;
        for (int k = 0; k <= W + 1; k++) begin
            if (k > 0) wait_cycle();
            if (k <= W) begin
                check("busy", 32'(bus.busy), 32'd1);
                check("done_low", 32'(bus.done), 32'd0);
                check("hold", 32'(observed()), 32'(last_out));
            end else begin
                check("busy_end", 32'(bus.busy), 32'd0);
                check("done_pulse", 32'(bus.done), 32'd1);
                if (exp_q.size() == 0) begin
                    check("queue_empty", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("digits", 32'(observed() & 17'h0ffff), 32'(exp[15:0]));
                    check("neg", 32'(bus.neg), 32'(exp[16]));
                    last_out = exp;
                end
            end
        end
    endtask

    initial begin
        n_checks        = 0;
        n_err           = 0;
        last_out        = '0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.value       = '0;
        bus.signed_mode = 1'b0;
        bus.hex_mode    = 1'b0;

        // Reset state
        repeat (2) wait_cycle();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_out", 32'(observed()), 32'd0);
        check("rst_state", 32'(bus.state), 32'(IDLE));
        rst = 1'b0;
        wait_cycle();

        // Directed conversions
        run_conv(8'hFF, 1'b0, 1'b0);   // 0255
        run_conv(8'h80, 1'b1, 1'b0);   // -128
        run_conv(8'h7F, 1'b1, 1'b0);   // 0127
        run_conv(8'h00, 1'b1, 1'b0);   // 0000, neg 0
        run_conv(8'hA7, 1'b1, 1'b1);   // hex 00A7, neg 0
        wait_cycle();
        check("done_single", 32'(bus.done), 32'd0);

        // Start while busy is dropped
        exp_q.push_back(model(8'h12, 1'b0, 1'b0));
        bus.value       = 8'h12;
        bus.signed_mode = 1'b0;
        bus.hex_mode    = 1'b0;
        bus.start       = 1'b1;
        wait_cycle();
        bus.start = 1'b0;
        for (int k = 1; k <= W + 4; k++) begin
            if (k == 3) begin
                bus.value = 8'h34;
                bus.start = 1'b1;
            end
            wait_cycle();
            bus.start = 1'b0;
            check("busy_ign_done", 32'(bus.done), (k == W + 1) ? 32'd1 : 32'd0);
            if (k == W + 1) begin
                last_out = exp_q.pop_front();
                check("busy_ign_out", 32'(observed()), 32'(last_out));
            end
        end
        check("busy_ign_hold", 32'(observed()), 32'h00018);

        // Reset mid-conversion
        bus.value = 8'hFF;
        bus.start = 1'b1;
        wait_cycle();
        bus.start = 1'b0;
        repeat (3) wait_cycle();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_out", 32'(observed()), 32'd0);
        wait_cycle();
        rst = 1'b0;
        last_out = '0;
        for (int k = 0; k < W + 3; k++) begin
            wait_cycle();
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        run_conv(8'h05, 1'b0, 1'b0);

        // Back-to-back: second start lands in the done cycle
        wait_cycle();
        run_conv(8'h09, 1'b0, 1'b0);
        run_conv(8'h63, 1'b0, 1'b0);

        // Random conversions with random idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) wait_cycle();
            run_conv(W'($urandom_range(0, (1 << W) - 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
